ay_turbosound: RTL and testbench



---
 rtl/ay_turbosound.sv | 128 ++++++++++++
 tb/tb_ay_turbosound.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/ay_turbosound.sv
// rtl/ay_turbosound.sv - TurboSound AY/YM bus strobe generator for 1..4 chips with AY clock divider
module ay_turbosound #(
  parameter int CHIPS          = 2,
  parameter int CLK_DIV        = 1,
  parameter int RECOVER_CYCLES = 2
) (
  input  logic             clk28,
  input  logic             rst,
  input  logic [15:0]      a,
  input  logic [7:0]       d,
  input  logic             ioreq,
  input  logic             rd,
  input  logic             wr,
  input  logic             ck35,
  input  logic             ts_en,
  output logic             ay_clk,
  output logic [CHIPS-1:0] ay_bc1,
  output logic [CHIPS-1:0] ay_bdir,
  output logic             ay_oe,
  output logic [1:0]       ay_sel
);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_INTERCEPT = 3'd1;
  localparam logic [2:0] S_LATCH     = 3'd2;
  localparam logic [2:0] S_READ      = 3'd3;
  localparam logic [2:0] S_WRITE     = 3'd4;
  localparam logic [2:0] S_RECOVER   = 3'd5;

  localparam logic [3:0]       DIV_MAX   = 4'(CLK_DIV - 1);
  localparam logic [3:0]       REC_LOAD  = 4'(RECOVER_CYCLES);
  localparam logic [2:0]       CHIPS_W   = 3'(CHIPS);
  localparam logic [CHIPS-1:0] ONE       = 1;
  localparam logic [2:0]       S_EXIT    = (RECOVER_CYCLES == 0) ? S_IDLE : S_RECOVER;

  logic [2:0] st, st_n;
  logic [3:0] rcnt, rcnt_n;
  logic [1:0] chip, chip_n;
  logic [1:0] sel_n;
  logic [3:0] div_cnt;

  logic       reg_wr, reg_rd, dat_wr, sel_wr;
  logic [1:0] sel_idx, eff_sel;
  logic       unused_addr;

  assign unused_addr = ^{a[13:2], a[0]};

  assign reg_wr  = a[15] & a[14] & ~a[1] & ioreq & wr;
  assign reg_rd  = a[15] & a[14] & ~a[1] & ioreq & rd;
  assign dat_wr  = a[15] & ~a[14] & ~a[1] & ioreq & wr;
  assign sel_idx = ~d[1:0];
  assign sel_wr  = reg_wr & ts_en & (d[7:2] == 6'b111111) & ({1'b0, sel_idx} < CHIPS_W);
  assign eff_sel = ts_en ? ay_sel : 2'd0;

  // Any change of decode class ends the current cycle; the new class is only picked up from IDLE.
  always_comb begin
    st_n   = st;
    rcnt_n = rcnt;
    chip_n = chip;
    sel_n  = eff_sel;
    case (st)
      S_IDLE: begin
        if (sel_wr) begin
          st_n  = S_INTERCEPT;
          sel_n = sel_idx;
        end else if (reg_wr) begin
          st_n   = S_LATCH;
          chip_n = eff_sel;
        end else if (reg_rd) begin
          st_n   = S_READ;
          chip_n = eff_sel;
        end else if (dat_wr) begin
          st_n   = S_WRITE;
          chip_n = eff_sel;
        end
      end
      S_INTERCEPT: if (!sel_wr) begin st_n = S_EXIT; rcnt_n = REC_LOAD; end
      S_LATCH:     if (!reg_wr) begin st_n = S_EXIT; rcnt_n = REC_LOAD; end
      S_READ:      if (!reg_rd) begin st_n = S_EXIT; rcnt_n = REC_LOAD; end
      S_WRITE:     if (!dat_wr) begin st_n = S_EXIT; rcnt_n = REC_LOAD; end
      S_RECOVER: begin
        if (rcnt <= 4'd1) begin
          st_n   = S_IDLE;
          rcnt_n = 4'd0;
        end else begin
          rcnt_n = rcnt - 4'd1;
        end
      end
      default: st_n = S_IDLE;
    endcase
  end

  // Strobes are decoded from the next state so they appear one clk28 after the decode.
  always_ff @(posedge clk28 or posedge rst) begin
    if (rst) begin
      st      <= S_IDLE;
      rcnt    <= 4'd0;
      chip    <= 2'd0;
      ay_sel  <= 2'd0;
      ay_bc1  <= '0;
      ay_bdir <= '0;
      ay_oe   <= 1'b0;
    end else begin
      st      <= st_n;
      rcnt    <= rcnt_n;
      chip    <= chip_n;
      ay_sel  <= sel_n;
      ay_bc1  <= (st_n == S_LATCH || st_n == S_READ)  ? (ONE << chip_n) : '0;
      ay_bdir <= (st_n == S_LATCH || st_n == S_WRITE) ? (ONE << chip_n) : '0;
      ay_oe   <= (st_n == S_READ);
    end
  end

  always_ff @(posedge clk28 or posedge rst) begin
    if (rst) begin
      div_cnt <= 4'd0;
      ay_clk  <= 1'b0;
    end else if (ck35) begin
      if (div_cnt == DIV_MAX) begin
        div_cnt <= 4'd0;
        ay_clk  <= ~ay_clk;
      end else begin
        div_cnt <= div_cnt + 4'd1;
      end
    end
  end

endmodule

// File: tb/tb_ay_turbosound.sv
// tb/tb_ay_turbosound.sv - directed scoreboard bench for ay_turbosound
module tb_ay_turbosound;

  logic        clk28 = 1'b0;
  logic        rst;
  logic [15:0] a;
  logic [7:0]  d;
  logic        ioreq, rd, wr, ck35, ts_en;
  logic        ay_clk, ay_oe, ay_clk3, ay_oe3;
  logic [1:0]  ay_bc1, ay_bdir, ay_sel, ay_bc13, ay_bdir3, ay_sel3;

  typedef struct {
    string       tag;
    logic [15:0] val;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  always #5 clk28 = ~clk28;

  ay_turbosound #(.CHIPS(2), .CLK_DIV(1), .RECOVER_CYCLES(2)) dut (
    .clk28(clk28), .rst(rst), .a(a), .d(d), .ioreq(ioreq), .rd(rd), .wr(wr),
    .ck35(ck35), .ts_en(ts_en), .ay_clk(ay_clk), .ay_bc1(ay_bc1),
    .ay_bdir(ay_bdir), .ay_oe(ay_oe), .ay_sel(ay_sel)
  );

  ay_turbosound #(.CHIPS(2), .CLK_DIV(3), .RECOVER_CYCLES(2)) dut3 (
    .clk28(clk28), .rst(rst), .a(a), .d(d), .ioreq(ioreq), .rd(rd), .wr(wr),
    .ck35(ck35), .ts_en(ts_en), .ay_clk(ay_clk3), .ay_bc1(ay_bc13),
    .ay_bdir(ay_bdir3), .ay_oe(ay_oe3), .ay_sel(ay_sel3)
  );

  function automatic logic [15:0] pk(logic [1:0] b1, logic [1:0] bd, logic oe, logic [1:0] s);
    return {9'b0, b1, bd, oe, s};
  endfunction

  function automatic logic [15:0] obs();
    return {9'b0, ay_bc1, ay_bdir, ay_oe, ay_sel};
  endfunction

  task automatic tick();
    @(posedge clk28);
    #2;
  endtask

  task automatic push(input string tag, input logic [15:0] v);
    exp_t e;
    e.tag = tag;
    e.val = v;
    sb.push_back(e);
  endtask

  task automatic pop_check(input logic [15:0] o);
    exp_t e;
    total++;
    if (sb.size() == 0) begin
      bad++;
      $error("FAIL scoreboard_empty observed=%h expected=none", o);
    end else begin
      e = sb.pop_front();
      assert (o === e.val) else begin
        bad++;
        $error("FAIL %s observed=%h expected=%h", e.tag, o, e.val);
      end
    end
  endtask

  task automatic step(input string tag, input logic [15:0] e);
    push(tag, e);
    tick();
    pop_check(obs());
  endtask

  task automatic bus(input logic [15:0] addr, input logic [7:0] data, input logic r, input logic w);
    a = addr; d = data; ioreq = r | w; rd = r; wr = w;
  endtask

  task automatic idle_gap(input string tag, input logic [1:0] s);
    bus(16'h0000, 8'h00, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step(tag, pk(2'b00, 2'b00, 1'b0, s));
  endtask

  logic m1, m3;
  int   c3;

  initial begin
    rst = 1'b1; ck35 = 1'b0; ts_en = 1'b1;
    bus(16'h0000, 8'h00, 1'b0, 1'b0);
    m1 = 1'b0; m3 = 1'b0; c3 = 0;

    push("reset_outputs", pk(2'b00, 2'b00, 1'b0, 2'b00));
    push("reset_ay_clk", 16'h0000);
    tick();
    pop_check(obs());
    pop_check({15'b0, ay_clk});
    rst = 1'b0;
    tick();

    // Divider: ck35 every 8 clk28, compared each cycle against both divide ratios.
    for (int i = 0; i < 64; i++) begin
      ck35 = (i % 8 == 0);
      if (ck35) begin
        m1 = ~m1;
        if (c3 == 2) begin c3 = 0; m3 = ~m3; end else c3++;
      end
      push("ay_clk_div1", {15'b0, m1});
      push("ay_clk_div3", {15'b0, m3});
      tick();
      pop_check({15'b0, ay_clk});
      pop_check({15'b0, ay_clk3});
    end
    ck35 = 1'b0;

    bus(16'hFFFD, 8'h07, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) step("latch_chip0", pk(2'b01, 2'b01, 1'b0, 2'd0));
    idle_gap("latch_recover", 2'd0);
    bus(16'hBFFD, 8'h38, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) step("write_chip0", pk(2'b00, 2'b01, 1'b0, 2'd0));
    idle_gap("write_recover", 2'd0);

    bus(16'hFFFD, 8'hFE, 1'b0, 1'b1);
    for (int i = 0; i < 2; i++) step("select_chip1", pk(2'b00, 2'b00, 1'b0, 2'd1));
    idle_gap("select_recover", 2'd1);
    bus(16'hBFFD, 8'h55, 1'b0, 1'b1);
    for (int i = 0; i < 2; i++) step("write_chip1", pk(2'b00, 2'b10, 1'b0, 2'd1));
    idle_gap("write1_recover", 2'd1);
    bus(16'hFFFD, 8'hFC, 1'b0, 1'b1);
    for (int i = 0; i < 2; i++) step("fc_is_latch", pk(2'b10, 2'b10, 1'b0, 2'd1));
    idle_gap("fc_recover", 2'd1);

    bus(16'hFFFD, 8'h00, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) step("read_chip1", pk(2'b10, 2'b00, 1'b1, 2'd1));
    idle_gap("read_recover", 2'd1);

    ts_en = 1'b0;
    bus(16'hFFFD, 8'hFE, 1'b0, 1'b1);
    for (int i = 0; i < 2; i++) step("ts_off_latch", pk(2'b01, 2'b01, 1'b0, 2'd0));
    bus(16'h0000, 8'h00, 1'b0, 1'b0);
    step("rec_a", pk(2'b00, 2'b00, 1'b0, 2'd0));
    bus(16'hFFFD, 8'h07, 1'b0, 1'b1);
    step("rec_short_in_recover", pk(2'b00, 2'b00, 1'b0, 2'd0));
    bus(16'h0000, 8'h00, 1'b0, 1'b0);
    step("rec_lost_b", pk(2'b00, 2'b00, 1'b0, 2'd0));
    step("rec_lost_idle", pk(2'b00, 2'b00, 1'b0, 2'd0));
    step("rec_lost_none", pk(2'b00, 2'b00, 1'b0, 2'd0));

    bus(16'hFFFD, 8'h08, 1'b0, 1'b1);
    step("b2b_first", pk(2'b01, 2'b01, 1'b0, 2'd0));
    bus(16'h0000, 8'h00, 1'b0, 1'b0);
    step("b2b_rec1", pk(2'b00, 2'b00, 1'b0, 2'd0));
    bus(16'hFFFD, 8'h09, 1'b0, 1'b1);
    step("b2b_rec2", pk(2'b00, 2'b00, 1'b0, 2'd0));
    step("b2b_idle", pk(2'b00, 2'b00, 1'b0, 2'd0));
    step("b2b_second", pk(2'b01, 2'b01, 1'b0, 2'd0));
    step("b2b_second_hold", pk(2'b01, 2'b01, 1'b0, 2'd0));
    idle_gap("b2b_recover", 2'd0);

    ts_en = 1'b1;
    bus(16'hFFFD, 8'hFE, 1'b0, 1'b1);
    step("reselect_chip1", pk(2'b00, 2'b00, 1'b0, 2'd1));
    idle_gap("reselect_recover", 2'd1);
    bus(16'hBFFD, 8'hAA, 1'b0, 1'b1);
    step("pre_reset_write", pk(2'b00, 2'b10, 1'b0, 2'd1));
    push("async_reset_drop", pk(2'b00, 2'b00, 1'b0, 2'd0));
    rst = 1'b1;
    #1;
    pop_check(obs());
    bus(16'h0000, 8'h00, 1'b0, 1'b0);
    tick();
    rst = 1'b0;
    step("post_reset_idle", pk(2'b00, 2'b00, 1'b0, 2'd0));
    bus(16'hBFFD, 8'h11, 1'b0, 1'b1);
    step("post_reset_write_chip0", pk(2'b00, 2'b01, 1'b0, 2'd0));
    idle_gap("final_recover", 2'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
